// File: rtl/alu_rr_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes, FSM states
// and opcode classification helpers.
package alu_rr_sched_pkg;

  localparam int DW_DEF  = 4;
  localparam int OPW_DEF = 3;

  localparam logic [OPW_DEF-1:0] OP_SUB = 3'b000;
  localparam logic [OPW_DEF-1:0] OP_ADD = 3'b001;
  localparam logic [OPW_DEF-1:0] OP_NOT = 3'b010;
  localparam logic [OPW_DEF-1:0] OP_OR  = 3'b011;
  localparam logic [OPW_DEF-1:0] OP_AND = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Legal opcodes span SUB through AND; higher encodings are flagged as errors.
  function automatic logic op_is_legal(input logic [OPW_DEF-1:0] op);
    return (op <= OP_AND);
  endfunction

  // Only SUB and ADD produce a meaningful overflow flag.
  function automatic logic op_is_arith(input logic [OPW_DEF-1:0] op);
    return (op == OP_SUB) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant: a lone valid requester wins outright; when both
// are valid the pointer picks the winner (0 -> requester 0).
module alu_rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_ptr,
  output logic o_gnt0,
  output logic o_gnt1,
  output logic o_id
);

  assign o_gnt0 = i_valid0 && (!i_valid1 || !i_ptr);
  assign o_gnt1 = i_valid1 && (!i_valid0 ||  i_ptr);
  assign o_id   = o_gnt1;

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one external ALU between two requesters: round-robin accept, hold the
// ALU operands for EXEC_CYCLES, capture and clean the result, return it per requester.
module alu_rr_sched
  import alu_rr_sched_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int OPW         = OPW_DEF,
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DW-1:0]    req0_a,
  input  logic [DW-1:0]    req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [DW-1:0]    resp0_r,
  output logic             resp0_ov,
  output logic             resp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DW-1:0]    req1_a,
  input  logic [DW-1:0]    req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [DW-1:0]    resp1_r,
  output logic             resp1_ov,
  output logic             resp1_err,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [DW-1:0]    alu_r,
  input  logic             alu_ov,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int            EW        = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [EW-1:0] EXEC_LAST = EW'(EXEC_CYCLES - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic             r_rr_ptr;
  logic             r_id;
  logic [OPW-1:0]   r_op;
  logic [EW-1:0]    r_exec_cnt;
  logic [DW-1:0]    r_alu_a;
  logic [DW-1:0]    r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic [DW-1:0]    r_res;
  logic             r_ov;
  logic             r_err;
  logic             r_resp_valid0;
  logic             r_resp_valid1;
  logic [CNT_W-1:0] r_op_count;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_id;
  logic             w_idle;
  logic             w_accept;
  logic             w_exec_last;
  logic             w_resp_hs;
  logic [DW-1:0]    w_sel_a;
  logic [DW-1:0]    w_sel_b;
  logic [OPW-1:0]   w_sel_op;

  alu_rr_arb2 u_arb (
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_ptr    (r_rr_ptr),
    .o_gnt0   (w_gnt0),
    .o_gnt1   (w_gnt1),
    .o_id     (w_id)
  );

  // Ready is only offered while idle and never during reset, so no handshake can slip past rst.
  assign w_idle      = (r_state == ST_IDLE) && !rst;
  assign req0_ready  = w_idle && w_gnt0;
  assign req1_ready  = w_idle && w_gnt1;
  assign w_accept    = w_idle && (w_gnt0 || w_gnt1);

  assign w_sel_a     = w_id ? req1_a  : req0_a;
  assign w_sel_b     = w_id ? req1_b  : req0_b;
  assign w_sel_op    = w_id ? req1_op : req0_op;

  assign w_exec_last = (r_state == ST_EXEC) && (r_exec_cnt == EXEC_LAST);
  assign w_resp_hs   = (r_state == ST_RESP) && (r_id ? resp1_ready : resp0_ready);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_EXEC;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (w_exec_last) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (w_resp_hs) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request latching, ALU drive, result capture and response bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr      <= 1'b0;
      r_id          <= 1'b0;
      r_op          <= {OPW{1'b0}};
      r_exec_cnt    <= {EW{1'b0}};
      r_alu_a       <= {DW{1'b0}};
      r_alu_b       <= {DW{1'b0}};
      r_alu_op      <= OP_SUB;
      r_res         <= {DW{1'b0}};
      r_ov          <= 1'b0;
      r_err         <= 1'b0;
      r_resp_valid0 <= 1'b0;
      r_resp_valid1 <= 1'b0;
      r_op_count    <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id       <= w_id;
            r_op       <= w_sel_op;
            r_exec_cnt <= {EW{1'b0}};
            // An illegal opcode leaves the ALU idle on SUB; its operands are not forwarded.
            if (op_is_legal(w_sel_op)) begin
              r_alu_a  <= w_sel_a;
              r_alu_b  <= w_sel_b;
              r_alu_op <= w_sel_op;
            end else begin
              r_alu_op <= OP_SUB;
            end
          end
        end
        ST_EXEC: begin
          if (w_exec_last) begin
            r_res         <= op_is_legal(r_op) ? alu_r : {DW{1'b0}};
            r_ov          <= op_is_arith(r_op) ? alu_ov : 1'b0;
            r_err         <= !op_is_legal(r_op);
            r_resp_valid0 <= !r_id;
            r_resp_valid1 <= r_id;
          end else begin
            r_exec_cnt <= r_exec_cnt + EW'(1);
          end
        end
        ST_RESP: begin
          if (w_resp_hs) begin
            r_resp_valid0 <= 1'b0;
            r_resp_valid1 <= 1'b0;
            r_rr_ptr      <= !r_id;
            if (r_op_count != {CNT_W{1'b1}}) begin
              r_op_count <= r_op_count + CNT_W'(1);
            end
          end
        end
        default: begin
          r_resp_valid0 <= 1'b0;
          r_resp_valid1 <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign resp0_valid = r_resp_valid0;
  assign resp1_valid = r_resp_valid1;
  assign resp0_r     = r_res;
  assign resp1_r     = r_res;
  assign resp0_ov    = r_ov;
  assign resp1_ov    = r_ov;
  assign resp0_err   = r_err;
  assign resp1_err   = r_err;
  assign busy        = (r_state != ST_IDLE);
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched with a stand-in ALU; directed cases then
// randomized traffic from both requesters against a plain-arithmetic model.
module tb_alu_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_ov, resp0_err;
  logic       req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_ov, resp1_err;
  logic [3:0] req0_a, req0_b, req1_a, req1_b, resp0_r, resp1_r;
  logic [2:0] req0_op, req1_op, alu_op;
  logic [3:0] alu_a, alu_b, alu_r;
  logic       alu_ov, busy;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;
  int n_resp = 0;
  int skip0  = 0;
  int skip1  = 0;
  bit rnd_on = 1'b0;

  typedef struct packed {
    logic [3:0] r;
    logic       ov;
    logic       err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  alu_rr_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_r(resp0_r), .resp0_ov(resp0_ov), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_r(resp1_r), .resp1_ov(resp1_ov), .resp1_err(resp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r), .alu_ov(alu_ov),
    .busy(busy), .op_count(op_count)
  );

  // Stand-in for ALU_TOP; it raises a junk overflow on logic ops and junk data on illegal ops.
  always_comb begin
    alu_r  = 4'h0;
    alu_ov = 1'b0;
    case (alu_op)
      3'b000: begin alu_r = alu_a - alu_b; alu_ov = (alu_a[3] != alu_b[3]) && (alu_r[3] != alu_a[3]); end
      3'b001: begin alu_r = alu_a + alu_b; alu_ov = (alu_a[3] == alu_b[3]) && (alu_r[3] != alu_a[3]); end
      3'b010: begin alu_r = ~alu_a;         alu_ov = 1'b1; end
      3'b011: begin alu_r = alu_a | alu_b;  alu_ov = 1'b1; end
      3'b100: begin alu_r = alu_a & alu_b;  alu_ov = 1'b1; end
      default: begin alu_r = alu_a ^ alu_b; alu_ov = 1'b1; end
    endcase
  end

  function automatic exp_t ref_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    exp_t e;
    int   sa;
    int   sb;
    int   s;
    e  = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0:    begin s = sa - sb; e.r = s[3:0]; e.ov = (s < -8) || (s > 7); end
      3'd1:    begin s = sa + sb; e.r = s[3:0]; e.ov = (s < -8) || (s > 7); end
      3'd2:    e.r = ~a;
      3'd3:    e.r = a | b;
      3'd4:    e.r = a & b;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    skip0  = 0;
    skip1  = 0;
    n_resp = 0;
  endtask

  // Holds the request until accepted (or for one cycle only when try_once is set).
  task automatic send(input int id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                      input bit try_once);
    bit acc;
    acc = 1'b0;
    set_req(id, 1'b1, a, b, op);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = (id == 0) ? req0_ready : req1_ready;
      tick();
      if (acc || try_once) break;
    end
    if (!acc && !try_once) chk($sformatf("send_timeout%0d", id), 0, 1);
    set_req(id, 1'b0, a, b, op);
  endtask

  task automatic wait_resp_done(input int id);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = (id == 0) ? (resp0_valid && resp0_ready) : (resp1_valid && resp1_ready);
    end
    if (!done) chk($sformatf("resp_timeout%0d", id), 0, 1);
    tick();
  endtask

  // Monitor: pushes expectations on request handshakes, pops and compares on response handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (req0_valid && req0_ready) q0.push_back(ref_model(req0_a, req0_b, req0_op));
      if (req1_valid && req1_ready) q1.push_back(ref_model(req1_a, req1_b, req1_op));
      if (req0_ready || req1_ready) chk("one_ready", int'(req0_ready && req1_ready), 0);
      if (resp0_valid || resp1_valid) chk("one_resp", int'(resp0_valid && resp1_valid), 0);
      if (resp0_valid && resp0_ready) begin
        if (q0.size() == 0) chk("resp0_unexpected", 1, 0);
        else begin e = q0.pop_front(); chk("resp0", {resp0_r, resp0_ov, resp0_err}, e); end
        n_resp++;
      end
      if (resp1_valid && resp1_ready) begin
        if (q1.size() == 0) chk("resp1_unexpected", 1, 0);
        else begin e = q1.pop_front(); chk("resp1", {resp1_r, resp1_ov, resp1_err}, e); end
        n_resp++;
      end
      // A continuously waiting requester may see the other side win at most once.
      if (!req1_valid || req1_ready) skip1 = 0;
      else if (req0_valid && req0_ready) begin skip1++; chk("starve1", int'(skip1 > 1), 0); end
      if (!req0_valid || req0_ready) skip0 = 0;
      else if (req1_valid && req1_ready) begin skip0++; chk("starve0", int'(skip0 > 1), 0); end
    end
  end

  // Random response back-pressure during the randomized phase.
  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drv(input int id);
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(id, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 5) == 0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    set_req(0, 1'b0, 4'h0, 4'h0, 3'b000);
    set_req(1, 1'b0, 4'h0, 4'h0, 3'b000);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    do_reset();

    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_count", op_count, 0);
    chk("rst_valid", {resp0_valid, resp1_valid}, 0);
    chk("rst_resp", {resp0_r, resp0_ov, resp0_err}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);

    // Single ADD 3+4 from requester 0.
    tick();
    set_req(0, 1'b1, 4'h3, 4'h4, 3'b001);
    @(negedge clk);
    chk("t1_ready0", req0_ready, 1);
    tick();
    set_req(0, 1'b0, 4'h0, 4'h0, 3'b000);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp0_valid) begin lat = i; break; end
    end
    chk("t1_latency", lat, 2);
    tick();
    @(negedge clk);
    chk("t1_count", op_count, 1);
    chk("t1_idle", {busy, resp0_valid}, 0);

    // Simultaneous requests after reset: requester 0 first, then requester 1.
    do_reset();
    set_req(0, 1'b1, 4'h7, 4'h1, 3'b001);
    set_req(1, 1'b1, 4'h4, 4'h5, 3'b000);
    @(negedge clk);
    chk("t2_ready", {req0_ready, req1_ready}, 2'b10);
    tick();
    set_req(0, 1'b0, 4'h0, 4'h0, 3'b000);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req1_ready) begin lat = 1; break; end
    end
    chk("t2_req1_granted", lat, 1);
    chk("t2_no_overlap", q0.size() + 2 * n_resp, 2);
    tick();
    set_req(1, 1'b0, 4'h0, 4'h0, 3'b000);
    wait_resp_done(1);

    // Logic op after an overflowing ADD: overflow must be masked.
    send(0, 4'h7, 4'h7, 3'b001, 1'b0);
    wait_resp_done(0);
    send(1, 4'hC, 4'hA, 3'b100, 1'b0);
    wait_resp_done(1);

    // Illegal opcode: ALU parked on SUB, error response.
    send(0, 4'h5, 4'h3, 3'b110, 1'b0);
    @(negedge clk);
    chk("t4_alu_op", alu_op, 0);
    wait_resp_done(0);

    // Response stall with requester 1 waiting.
    resp0_ready = 1'b0;
    send(0, 4'h2, 4'h9, 3'b001, 1'b0);
    set_req(1, 1'b1, 4'h6, 4'h6, 3'b011);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp0_valid) begin lat = 1; break; end
    end
    chk("t5_resp_seen", lat, 1);
    repeat (5) begin
      chk("t5_stall", {resp0_valid, resp0_r, req1_ready, alu_op}, {1'b1, 4'hB, 1'b0, 3'b001});
      @(negedge clk);
    end
    tick();
    resp0_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t5_req1_granted", req1_ready, 1);
    tick();
    set_req(1, 1'b0, 4'h0, 4'h0, 3'b000);
    wait_resp_done(1);

    // Reset while executing: op discarded.
    do_reset();
    send(0, 4'h1, 4'h1, 3'b001, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q0.delete();
    repeat (4) begin
      @(negedge clk);
      chk("t6_abort", {busy, resp0_valid, op_count}, 0);
    end

    // Randomized traffic from both requesters.
    do_reset();
    rnd_on = 1'b1;
    fork
      drv(0);
      drv(1);
    join
    rnd_on = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      if (q0.size() == 0 && q1.size() == 0 && !resp0_valid && !resp1_valid) break;
    end
    chk("drain_q", q0.size() + q1.size(), 0);
    tick();
    @(negedge clk);
    chk("rnd_count", op_count, n_resp);
    chk("rnd_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
